// File: rtl/bus_hub_n.sv
// N-channel burst gather hub: round-robin input grant, shared FIFO, one output.
// Define BUS_HUB_N_PRIORITY_EN for fixed lowest-index-first grant.
module bus_hub_n #(
  parameter int SPI_WIDTH  = 32,
  parameter int NUM_CH     = 4,
  parameter int BURST_LEN  = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           ch_en,
  output logic [NUM_CH-1:0]           config_req_F,
  input  logic [NUM_CH-1:0]           config_ready_F,
  output logic [NUM_CH-1:0]           data_request,
  input  logic [NUM_CH-1:0]           ready_real_BUS,
  input  logic [NUM_CH*SPI_WIDTH-1:0] data_in,
  output logic [NUM_CH*4-1:0]         which_write,
  output logic                        config_req_out,
  input  logic                        config_ready_out,
  output logic                        write_req_out,
  input  logic                        ready_BUS_out,
  output logic [SPI_WIDTH-1:0]        data_out_BUS,
  output logic [3:0]                  which_write_out
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int QD = FIFO_DEPTH / BURST_LEN;
  localparam int QW = (QD > 1) ? $clog2(QD) : 1;
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {IDLE, CFG, DATA} in_st_t;
  typedef enum logic [1:0] {O_IDLE, O_CFG, O_DATA} out_st_t;

  in_st_t  in_st;
  out_st_t out_st;

  logic [CW-1:0] g;
  logic [CW-1:0] sel;
  logic          found;
  logic [BW-1:0] wcnt;
  logic [BW-1:0] rcnt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic [QW-1:0] q_wr;
  logic [QW-1:0] q_rd;
  logic [QW:0]   bcnt;
  logic          push;
  logic          pop;
  logic          last_in;
  logic          last_out;
  logic          room;

  logic [SPI_WIDTH-1:0] mem  [FIFO_DEPTH];
  logic [CW-1:0]        qmem [QD];

`ifndef BUS_HUB_N_PRIORITY_EN
  logic [CW-1:0] ptr;
`endif

  assign push     = (in_st == DATA) && ready_real_BUS[g];
  assign pop      = write_req_out && ready_BUS_out;
  assign last_in  = push && (wcnt == BW'(BURST_LEN - 1));
  assign last_out = pop && (rcnt == BW'(BURST_LEN - 1));
  assign room     = (FIFO_DEPTH - int'(cnt)) >= BURST_LEN;

  assign data_out_BUS = write_req_out ? mem[rd_ptr] : '0;

  always_comb begin
    sel   = '0;
    found = 1'b0;
`ifdef BUS_HUB_N_PRIORITY_EN
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (ch_en[k]) begin
        sel   = CW'(k);
        found = 1'b1;
      end
    end
`else
    for (int k = 0; k < NUM_CH; k++) begin
      int j;
      j = (int'(ptr) + k) % NUM_CH;
      if (!found && ch_en[j]) begin
        sel   = CW'(j);
        found = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_st        <= IDLE;
      g            <= '0;
      wcnt         <= '0;
      config_req_F <= '0;
      data_request <= '0;
      which_write  <= '0;
`ifndef BUS_HUB_N_PRIORITY_EN
      ptr          <= '0;
`endif
    end else begin
      unique case (in_st)
        IDLE: begin
          if (found && room) begin
            g            <= sel;
            config_req_F <= NUM_CH'(1) << sel;
            in_st        <= CFG;
          end
        end
        CFG: begin
          if (config_ready_F[g]) begin
            config_req_F <= '0;
            data_request <= NUM_CH'(1) << g;
            wcnt         <= '0;
            in_st        <= DATA;
          end
        end
        DATA: begin
          if (push) begin
            wcnt <= wcnt + 1'b1;
            if (last_in) begin
              data_request         <= '0;
              which_write[g*4 +: 4] <= which_write[g*4 +: 4] + 4'd1;
              in_st                <= IDLE;
`ifndef BUS_HUB_N_PRIORITY_EN
              ptr <= (g == CW'(NUM_CH - 1)) ? '0 : g + 1'b1;
`endif
            end
          end
        end
        default: in_st <= IDLE;
      endcase
    end
  end

  // Data and burst-ID storage carry no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in[g*SPI_WIDTH +: SPI_WIDTH];
    if (last_in) qmem[q_wr] <= g;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      q_wr   <= '0;
      q_rd   <= '0;
      bcnt   <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (last_in)
        q_wr <= (q_wr == QW'(QD - 1)) ? '0 : q_wr + 1'b1;
      if (last_out)
        q_rd <= (q_rd == QW'(QD - 1)) ? '0 : q_rd + 1'b1;
      cnt  <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      bcnt <= bcnt + (QW+1)'(last_in) - (QW+1)'(last_out);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_st          <= O_IDLE;
      rcnt            <= '0;
      config_req_out  <= 1'b0;
      write_req_out   <= 1'b0;
      which_write_out <= '0;
    end else begin
      unique case (out_st)
        O_IDLE: begin
          if (bcnt != '0) begin
            which_write_out <= 4'(qmem[q_rd]);
            config_req_out  <= 1'b1;
            out_st          <= O_CFG;
          end
        end
        O_CFG: begin
          if (config_ready_out) begin
            config_req_out <= 1'b0;
            write_req_out  <= 1'b1;
            rcnt           <= '0;
            out_st         <= O_DATA;
          end
        end
        O_DATA: begin
          if (pop) begin
            rcnt <= rcnt + 1'b1;
            if (last_out) begin
              write_req_out <= 1'b0;
              out_st        <= O_IDLE;
            end
          end
        end
        default: out_st <= O_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_hub_n.sv
// Randomized bench for bus_hub_n with a burst-order reference model.
// Honours BUS_HUB_N_PRIORITY_EN when predicting grants.
module tb_bus_hub_n;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int BL = 4;
  localparam int FD = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   ch_en;
  logic [N-1:0]   config_req_F;
  logic [N-1:0]   config_ready_F;
  logic [N-1:0]   data_request;
  logic [N-1:0]   ready_real_BUS;
  logic [N*W-1:0] data_in;
  logic [N*4-1:0] which_write;
  logic           config_req_out;
  logic           config_ready_out;
  logic           write_req_out;
  logic           ready_BUS_out;
  logic [W-1:0]   data_out_BUS;
  logic [3:0]     which_write_out;

  bus_hub_n #(
    .SPI_WIDTH(W), .NUM_CH(N), .BURST_LEN(BL), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ch_en(ch_en),
    .config_req_F(config_req_F), .config_ready_F(config_ready_F),
    .data_request(data_request), .ready_real_BUS(ready_real_BUS),
    .data_in(data_in), .which_write(which_write),
    .config_req_out(config_req_out), .config_ready_out(config_ready_out),
    .write_req_out(write_req_out), .ready_BUS_out(ready_BUS_out),
    .data_out_BUS(data_out_BUS), .which_write_out(which_write_out)
  );

  always #5 clk = ~clk;

  int         n_pass = 0;
  int         n_checks = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int         grant_q[$];
  int         wwo_q[$];
  logic [W-1:0] next_word [N];
  int         seq [N];
  bit         fixed_mode, cfg_rand, valid_rand, out_rand, out_hold;
  int         model_ptr;
  int         model_cnt [N];

  function automatic int pred_grant(int ptr, logic [N-1:0] en);
`ifdef BUS_HUB_N_PRIORITY_EN
    for (int k = 0; k < N; k++) if (en[k]) return k;
`else
    for (int k = 0; k < N; k++) if (en[(ptr + k) % N]) return (ptr + k) % N;
`endif
    return -1;
  endfunction

  initial begin
    config_ready_F = '0;
    ready_real_BUS = '0;
    data_in = '0;
    config_ready_out = 1'b0;
    ready_BUS_out = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        config_ready_F[i] = config_req_F[i] &&
          (!cfg_rand || ($urandom_range(0, 1) == 1));
        ready_real_BUS[i] = valid_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        data_in[i*W +: W] = next_word[i];
      end
      config_ready_out = config_req_out &&
        (!cfg_rand || ($urandom_range(0, 1) == 1));
      ready_BUS_out = !out_hold &&
        (!out_rand || ($urandom_range(0, 1) == 1));
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (rst_n === 1'b1) begin
        for (int i = 0; i < N; i++) begin
          if (data_request[i] && ready_real_BUS[i]) begin
            exp_q.push_back(next_word[i]);
            seq[i]++;
            next_word[i] = fixed_mode ? (32'hA0 + 32'(seq[i])) : $urandom;
          end
          if (config_req_F[i] && config_ready_F[i]) grant_q.push_back(i);
        end
        if (config_req_out && config_ready_out)
          wwo_q.push_back(int'(which_write_out));
        if (write_req_out && ready_BUS_out) obs_q.push_back(data_out_BUS);
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    ch_en = '0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    obs_q.delete();
    grant_q.delete();
    wwo_q.delete();
    model_ptr = 0;
    for (int i = 0; i < N; i++) model_cnt[i] = 0;
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_q(input int which, input int n, input int budget,
                        output bit to);
    int t;
    t = 0;
    while (t < budget &&
           ((which == 0) ? grant_q.size() :
            (which == 1) ? obs_q.size() : exp_q.size()) < n) begin
      @(negedge clk);
      t++;
    end
    to = (t >= budget);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++; if (config_req_F !== '0) $display("FAIL rst_cfg_req: got %h want 0", config_req_F); else n_pass++;
    n_checks++; if (data_request !== '0) $display("FAIL rst_data_req: got %h want 0", data_request); else n_pass++;
    n_checks++; if (which_write !== '0) $display("FAIL rst_which_write: got %h want 0", which_write); else n_pass++;
    n_checks++; if (config_req_out !== 1'b0) $display("FAIL rst_cfg_out: got %b want 0", config_req_out); else n_pass++;
    n_checks++; if (write_req_out !== 1'b0) $display("FAIL rst_wr_out: got %b want 0", write_req_out); else n_pass++;
    n_checks++; if (data_out_BUS !== '0) $display("FAIL rst_data_out: got %h want 0", data_out_BUS); else n_pass++;
    n_checks++; if (which_write_out !== 4'd0) $display("FAIL rst_wwo: got %h want 0", which_write_out); else n_pass++;
  endtask

  task automatic test_single();
    bit to;
    int p;
    fixed_mode = 1'b1;
    seq[0] = 0;
    next_word[0] = 32'hA0;
    @(negedge clk);
    ch_en = 4'b0001;
    wait_q(0, 1, 50, to);
    ch_en = '0;
    n_checks++; if (to) $display("FAIL single_grant_wait: got timeout want grant"); else n_pass++;
    wait_q(1, 4, 100, to);
    repeat (10) @(negedge clk);
    fixed_mode = 1'b0;
    n_checks++; if (to) $display("FAIL single_drain_wait: got timeout want 4 words"); else n_pass++;
    n_checks++; if (obs_q.size() !== 4) $display("FAIL single_count: got %0d want 4", obs_q.size()); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (k >= obs_q.size() || obs_q[k] !== 32'hA0 + 32'(k))
        $display("FAIL single_word[%0d]: got %h want %h", k, (k < obs_q.size()) ? obs_q[k] : 'x, 32'hA0 + 32'(k));
      else n_pass++;
    end
    n_checks++; if (grant_q.size() !== 1 || grant_q[0] !== 0) $display("FAIL single_grant: got %0d grants want one on ch 0", grant_q.size()); else n_pass++;
    n_checks++; if (which_write_out !== 4'd0) $display("FAIL single_wwo: got %0d want 0", which_write_out); else n_pass++;
    n_checks++; if (which_write[3:0] !== 4'd1) $display("FAIL single_which_write: got %0d want 1", which_write[3:0]); else n_pass++;
    n_checks++; if (which_write[15:4] !== '0) $display("FAIL single_other_ww: got %h want 0", which_write[15:4]); else n_pass++;
    p = pred_grant(model_ptr, 4'b0001);
    model_cnt[p]++;
    model_ptr = (p + 1) % N;
  endtask

  task automatic test_stream(input string nm, input logic [N-1:0] en,
                             input int bursts, input bit rnd);
    bit to;
    int p;
    do_reset();
    cfg_rand = rnd;
    valid_rand = rnd;
    out_rand = rnd;
    @(negedge clk);
    ch_en = en;
    wait_q(0, bursts, 4000, to);
    ch_en = '0;
    n_checks++; if (to) $display("FAIL %s_grant_wait: got %0d grants want %0d", nm, grant_q.size(), bursts); else n_pass++;
    wait_q(1, BL * grant_q.size(), 4000, to);
    repeat (20) @(negedge clk);
    cfg_rand = 1'b0;
    valid_rand = 1'b0;
    out_rand = 1'b0;
    n_checks++; if (to) $display("FAIL %s_drain_wait: got %0d words want %0d", nm, obs_q.size(), BL * grant_q.size()); else n_pass++;
    n_checks++; if (exp_q.size() !== BL * grant_q.size()) $display("FAIL %s_in_count: got %0d want %0d", nm, exp_q.size(), BL * grant_q.size()); else n_pass++;
    n_checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL %s_out_count: got %0d want %0d", nm, obs_q.size(), exp_q.size()); else n_pass++;
    foreach (grant_q[k]) begin
      p = pred_grant(model_ptr, en);
      n_checks++;
      if (grant_q[k] !== p) $display("FAIL %s_grant[%0d]: got %0d want %0d", nm, k, grant_q[k], p);
      else n_pass++;
      n_checks++;
      if (k >= wwo_q.size() || wwo_q[k] !== p)
        $display("FAIL %s_wwo[%0d]: got %0d want %0d", nm, k, (k < wwo_q.size()) ? wwo_q[k] : -1, p);
      else n_pass++;
      model_cnt[p]++;
      model_ptr = (p + 1) % N;
    end
    foreach (exp_q[k]) begin
      n_checks++;
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k])
        $display("FAIL %s_word[%0d]: got %h want %h", nm, k, (k < obs_q.size()) ? obs_q[k] : 'x, exp_q[k]);
      else n_pass++;
    end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (which_write[i*4 +: 4] !== 4'(model_cnt[i]))
        $display("FAIL %s_which_write[%0d]: got %0d want %0d", nm, i, which_write[i*4 +: 4], 4'(model_cnt[i]));
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int p;
    do_reset();
    out_hold = 1'b1;
    @(negedge clk);
    ch_en = 4'b1111;
    repeat (200) @(negedge clk);
    n_checks++; if (grant_q.size() !== 4) $display("FAIL bp_grants: got %0d want 4", grant_q.size()); else n_pass++;
    n_checks++; if (exp_q.size() !== 16) $display("FAIL bp_in_words: got %0d want 16", exp_q.size()); else n_pass++;
    n_checks++; if (obs_q.size() !== 0) $display("FAIL bp_out_words: got %0d want 0", obs_q.size()); else n_pass++;
    n_checks++; if (config_req_F !== '0) $display("FAIL bp_no_cfg_req: got %h want 0", config_req_F); else n_pass++;
    ch_en = '0;
    out_hold = 1'b0;
    wait_q(1, 16, 400, to);
    repeat (10) @(negedge clk);
    n_checks++; if (to) $display("FAIL bp_drain_wait: got %0d words want 16", obs_q.size()); else n_pass++;
    n_checks++; if (obs_q.size() !== 16) $display("FAIL bp_drain_count: got %0d want 16", obs_q.size()); else n_pass++;
    foreach (grant_q[k]) begin
      p = pred_grant(model_ptr, 4'b1111);
      n_checks++;
      if (k >= wwo_q.size() || wwo_q[k] !== p)
        $display("FAIL bp_wwo[%0d]: got %0d want %0d", k, (k < wwo_q.size()) ? wwo_q[k] : -1, p);
      else n_pass++;
      model_ptr = (p + 1) % N;
    end
    foreach (exp_q[k]) begin
      n_checks++;
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k])
        $display("FAIL bp_word[%0d]: got %h want %h", k, (k < obs_q.size()) ? obs_q[k] : 'x, exp_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    do_reset();
    @(negedge clk);
    ch_en = 4'b0001;
    wait_q(2, 2, 100, to);
    n_checks++; if (to) $display("FAIL mid_wait: got %0d words want 2", exp_q.size()); else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (data_request !== '0) $display("FAIL mid_data_req: got %h want 0", data_request); else n_pass++;
    n_checks++; if (config_req_F !== '0) $display("FAIL mid_cfg_req: got %h want 0", config_req_F); else n_pass++;
    n_checks++; if (which_write !== '0) $display("FAIL mid_which_write: got %h want 0", which_write); else n_pass++;
    n_checks++; if ({config_req_out, write_req_out} !== 2'b00) $display("FAIL mid_out_hs: got %b want 00", {config_req_out, write_req_out}); else n_pass++;
    n_checks++; if (data_out_BUS !== '0) $display("FAIL mid_data_out: got %h want 0", data_out_BUS); else n_pass++;
    ch_en = '0;
    do_reset();
    @(negedge clk);
    ch_en = 4'b0001;
    wait_q(0, 1, 50, to);
    ch_en = '0;
    wait_q(1, 4, 100, to);
    repeat (20) @(negedge clk);
    n_checks++; if (to) $display("FAIL mid_post_wait: got %0d words want 4", obs_q.size()); else n_pass++;
    n_checks++; if (obs_q.size() !== 4) $display("FAIL mid_post_count: got %0d want 4", obs_q.size()); else n_pass++;
    foreach (exp_q[k]) begin
      n_checks++;
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k])
        $display("FAIL mid_word[%0d]: got %h want %h", k, (k < obs_q.size()) ? obs_q[k] : 'x, exp_q[k]);
      else n_pass++;
    end
    n_checks++; if (which_write[3:0] !== 4'd1) $display("FAIL mid_which_write0: got %0d want 1", which_write[3:0]); else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    ch_en = '0;
    for (int i = 0; i < N; i++) begin
      next_word[i] = $urandom;
      seq[i] = 0;
    end
    test_reset();
    test_single();
    test_stream("rr", 4'b1111, 5, 1'b0);
    test_stream("two", 4'b0110, 6, 1'b0);
    test_backpressure();
    test_stream("rand", 4'($urandom_range(1, 15)), 10, 1'b1);
    test_stream("rand2", 4'($urandom_range(1, 15)), 8, 1'b1);
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
